// File: rtl/bus_pkg.sv
// Shared defaults and FSM encoding for the bus arbiter slice.
package bus_pkg;

  localparam int unsigned ARRAY_SIZE_DEF = 16;
  localparam int unsigned LEN_W_DEF      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant/bus-drive signal bundle between requesters and the arbiter.
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) ();

  localparam int unsigned IDX_W = $clog2(ARRAY_SIZE);

  logic                        en;
  logic [ARRAY_SIZE-1:0]       req;
  logic [ARRAY_SIZE*LEN_W-1:0] len;
  logic                        stall;
  logic [ARRAY_SIZE-1:0]       grant;
  logic [ARRAY_SIZE-1:0]       bus_valid;
  logic [ARRAY_SIZE-1:0]       done;
  logic                        busy;
  logic [IDX_W-1:0]            owner;

  modport master (
    output en, req, len, stall,
    input  grant, bus_valid, done, busy, owner
  );

  modport slave (
    input  en, req, len, stall,
    output grant, bus_valid, done, busy, owner
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit at or above rr_ptr, wrapping.
module rr_picker
  import bus_pkg::*;
#(
  parameter  int unsigned ARRAY_SIZE = ARRAY_SIZE_DEF,
  localparam int unsigned IDX_W      = $clog2(ARRAY_SIZE)
) (
  input  logic [ARRAY_SIZE-1:0] req,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [ARRAY_SIZE-1:0] winner,
  output logic [IDX_W-1:0]      index,
  output logic                  any_valid
);

  always_comb begin
    int unsigned k;
    winner    = '0;
    index     = '0;
    any_valid = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
      k = (32'(rr_ptr) + i) % ARRAY_SIZE;
      if (!any_valid && req[k]) begin
        any_valid = 1'b1;
        index     = IDX_W'(k);
        winner[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin burst arbiter: grants one requester for len beats, stall holds the burst.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  bus_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ARRAY_SIZE);

  state_t                state, state_nx;
  logic [ARRAY_SIZE-1:0] grant_q, grant_nx;
  logic [IDX_W-1:0]      owner_q, owner_nx;
  logic [LEN_W-1:0]      cnt_q, cnt_nx;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_nx;

  logic [ARRAY_SIZE-1:0] pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [LEN_W-1:0]      win_len;
  logic                  beat;
  logic                  last_beat;

  rr_picker #(
    .ARRAY_SIZE (ARRAY_SIZE)
  ) u_picker (
    .req       (bus.req),
    .rr_ptr    (rr_ptr_q),
    .winner    (pick_onehot),
    .index     (pick_idx),
    .any_valid (pick_any)
  );

  assign win_len   = bus.len[32'(pick_idx)*LEN_W +: LEN_W];
  assign beat      = (state == BURST) && !bus.stall;
  assign last_beat = beat && (cnt_q == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state    <= state_nx;
      grant_q  <= grant_nx;
      owner_q  <= owner_nx;
      cnt_q    <= cnt_nx;
      rr_ptr_q <= rr_ptr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant_q;
    owner_nx  = owner_q;
    cnt_nx    = cnt_q;
    rr_ptr_nx = rr_ptr_q;
    if (state == IDLE) begin
      if (bus.en && pick_any) begin
        state_nx = BURST;
        grant_nx = pick_onehot;
        owner_nx = pick_idx;
        // A programmed length of zero still moves one beat
        cnt_nx   = (win_len == '0) ? LEN_W'(1) : win_len;
      end
    end else if (beat) begin
      if (last_beat) begin
        state_nx  = IDLE;
        grant_nx  = '0;
        owner_nx  = '0;
        cnt_nx    = '0;
        rr_ptr_nx = (owner_q == IDX_W'(ARRAY_SIZE - 1)) ? '0 : owner_q + 1'b1;
      end else begin
        cnt_nx = cnt_q - 1'b1;
      end
    end
  end

  // bus_valid and done stay combinational so the data buses see them in the beat cycle
  assign bus.grant     = grant_q;
  assign bus.bus_valid = grant_q & {ARRAY_SIZE{~bus.stall}};
  assign bus.done      = last_beat ? grant_q : '0;
  assign bus.busy      = (state == BURST);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter with hand-computed expectations.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned LW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ARRAY_SIZE(N), .LEN_W(LW)) bus ();

  bus_arbiter #(.ARRAY_SIZE(N), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] g, input logic [15:0] bv,
                          input logic [15:0] d, input logic b, input logic [3:0] o);
    chk({tag, ".grant"},     32'(bus.grant),     32'(g));
    chk({tag, ".bus_valid"}, 32'(bus.bus_valid), 32'(bv));
    chk({tag, ".done"},      32'(bus.done),      32'(d));
    chk({tag, ".busy"},      32'(bus.busy),      32'(b));
    chk({tag, ".owner"},     32'(bus.owner),     32'(o));
  endtask

  initial begin
    logic [6:0] stall_pat;
    int         beats;
    bus.en    = 1'b0;
    bus.req   = '0;
    bus.len   = '0;
    bus.stall = 1'b0;

    #1;
    chk_outs("reset", 16'h0, 16'h0, 16'h0, 1'b0, 4'd0);
    #11 rst_n = 1'b1;

    // single requester, lane 3, two beats
    bus.en = 1'b1;
    bus.req = 16'h0008;
    bus.len[3*LW +: LW] = 4'd2;
    cyc();
    chk_outs("single_b1", 16'h0008, 16'h0008, 16'h0000, 1'b1, 4'd3);
    bus.req = '0;
    cyc();
    chk_outs("single_b2", 16'h0008, 16'h0008, 16'h0008, 1'b1, 4'd3);
    cyc();
    chk_outs("single_end", 16'h0, 16'h0, 16'h0, 1'b0, 4'd0);

    // zero length on lane 0; search wraps from pointer 4 down to 0
    bus.req = 16'h0001;
    bus.len = '0;
    cyc();
    chk_outs("zlen_b1", 16'h0001, 16'h0001, 16'h0001, 1'b1, 4'd0);
    bus.req = '0;
    cyc();
    chk_outs("zlen_end", 16'h0, 16'h0, 16'h0, 1'b0, 4'd0);

    // two requesters from pointer 1: owner 1, bubble, then owner 0
    bus.req = 16'h0003;
    cyc();
    chk_outs("rr_a", 16'h0002, 16'h0002, 16'h0002, 1'b1, 4'd1);
    cyc();
    chk_outs("rr_bubble", 16'h0, 16'h0, 16'h0, 1'b0, 4'd0);
    cyc();
    chk_outs("rr_b", 16'h0001, 16'h0001, 16'h0001, 1'b1, 4'd0);
    bus.req = '0;
    cyc();
    chk("rr_idle.busy", 32'(bus.busy), 32'd0);

    // stall: four beats over seven cycles, len changed after grant has no effect
    bus.req = 16'h0020;
    bus.len[5*LW +: LW] = 4'd4;
    stall_pat = 7'b0001110;
    beats = 0;
    cyc();
    bus.req = '0;
    bus.len = '0;
    for (int i = 0; i < 7; i++) begin
      bus.stall = stall_pat[i];
      settle();
      if (bus.bus_valid != '0) beats++;
      chk($sformatf("stall_c%0d.bus_valid", i), 32'(bus.bus_valid),
          stall_pat[i] ? 32'h0 : 32'h0020);
      chk($sformatf("stall_c%0d.done", i), 32'(bus.done), (i == 6) ? 32'h0020 : 32'h0);
      chk($sformatf("stall_c%0d.grant", i), 32'(bus.grant), 32'h0020);
      if (i < 6) cyc();
    end
    bus.stall = 1'b0;
    cyc();
    chk("stall_beats", 32'(beats), 32'd4);
    chk("stall_end.busy", 32'(bus.busy), 32'd0);

    // enable low blocks all requests
    bus.en = 1'b0;
    bus.req = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("en_off%0d.grant", i), 32'(bus.grant), 32'h0);
      chk($sformatf("en_off%0d.bus_valid", i), 32'(bus.bus_valid), 32'h0);
    end

    // dropping en and req mid-burst does not shorten it
    bus.en = 1'b1;
    bus.req = 16'h0100;
    bus.len = {N{4'd3}};
    cyc();
    bus.en = 1'b0;
    bus.req = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("en_drop_b%0d.bus_valid", i), 32'(bus.bus_valid), 32'h0100);
      chk($sformatf("en_drop_b%0d.done", i), 32'(bus.done), (i == 2) ? 32'h0100 : 32'h0);
      cyc();
    end
    chk("en_drop_end.busy", 32'(bus.busy), 32'd0);

    // single requester held high: one idle cycle between grants
    bus.en = 1'b1;
    bus.req = 16'h0004;
    bus.len = '0;
    cyc();
    chk("rereq_g1.grant", 32'(bus.grant), 32'h0004);
    cyc();
    chk("rereq_gap.grant", 32'(bus.grant), 32'h0);
    cyc();
    chk("rereq_g2.grant", 32'(bus.grant), 32'h0004);
    bus.req = '0;
    cyc();

    // reset on beat 2 of a 4-beat burst, then restart from index 0
    bus.req = 16'hFFFF;
    bus.len = {N{4'd4}};
    cyc();
    chk("mid_b1.owner", 32'(bus.owner), 32'd3);
    cyc();
    chk("mid_b2.bus_valid", 32'(bus.bus_valid), 32'h0008);
    rst_n = 1'b0;
    settle();
    chk_outs("mid_reset", 16'h0, 16'h0, 16'h0, 1'b0, 4'd0);
    bus.len = {N{4'd1}};
    #3 rst_n = 1'b1;

    // all requesting, one beat each: owners 0..15 then 0 again
    for (int k = 0; k < 17; k++) begin
      cyc();
      chk($sformatf("all_k%0d.owner", k), 32'(bus.owner), 32'(k % 16));
      chk($sformatf("all_k%0d.done", k), 32'(bus.done), 32'(1) << (k % 16));
      cyc();
      chk($sformatf("all_k%0d.gap", k), 32'(bus.grant), 32'h0);
    end
    bus.req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ARRAY_SIZE, 16: number of requesters, equal to the data-bus width in lanes.
REQ-002 Parameter LEN_W, 4: width of each per-requester burst-length field.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port en  input  1: arbitration enable; sampled only in IDLE.
REQ-006 Port req  input  ARRAY_SIZE: per-requester level request.
REQ-007 Port len  input  ARRAY_SIZE*LEN_W: per-requester burst length in beats, lane i at bits [(i+1)*LEN_W-1 : i*LEN_W]; 0 means 1 beat.
REQ-008 Port stall  input  1: downstream not ready; no beat transfers in a stalled cycle.
REQ-009 Port grant  output  ARRAY_SIZE: registered one-hot owner, all-zero when idle.
REQ-010 Port bus_valid  output  ARRAY_SIZE: one-hot drive for the data bus's valid_in, equal to grant AND NOT stall.
REQ-011 Port done  output  ARRAY_SIZE: one-cycle pulse on the owner's last transferred beat.
REQ-012 Port busy  output  1: high while in BURST.
REQ-013 Port owner  output  clog2(ARRAY_SIZE): binary index of the current owner, 0 when idle.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST.
REQ-015 IDLE with en=1 and req!=0: winner SHALL be the first set req bit at or after rr_ptr, searching upward with wrap from ARRAY_SIZE-1 to 0.
REQ-016 At that edge the block SHALL register grant=onehot(winner), owner=winner, and cnt=max(len[winner],1), then enter BURST.
REQ-017 In BURST, every cycle with stall=0 SHALL be one beat, and cnt SHALL decrement by 1.
REQ-018 In BURST, a cycle with stall=1 SHALL hold cnt, grant and state, and SHALL drive bus_valid=0.
REQ-019 A beat with cnt=1 SHALL pulse done[owner] in that same cycle.
REQ-020 At the edge after that beat: rr_ptr SHALL become (owner+1) mod ARRAY_SIZE; grant, owner and busy SHALL clear; state SHALL return to IDLE.
REQ-021 IDLE SHALL last at least one cycle between bursts; back-to-back requesters therefore see a one-cycle bubble.
REQ-022 len SHALL be sampled only at grant; later changes to len have no effect on the current burst.
REQ-023 Deasserting req[owner], or en, during BURST SHALL NOT shorten or pre-empt the burst.
REQ-024 IDLE with en=0 or req=0 SHALL keep grant=0, bus_valid=0 and rr_ptr unchanged.
REQ-025 At most one bit of grant and of bus_valid SHALL ever be set.
REQ-026 A single requester re-requesting SHALL be re-granted after exactly one IDLE cycle.

Reset
REQ-027 rst_n=0 SHALL immediately clear state to IDLE, and set grant, bus_valid, done, busy, owner, cnt and rr_ptr to 0, including mid-burst.
REQ-028 The first arbitration after reset release SHALL start the search at index 0.

Structure
REQ-029 Shared package bus_pkg SHALL hold the default ARRAY_SIZE and LEN_W, and the FSM state encoding (IDLE=0, BURST=1).
REQ-030 The round-robin winner search SHALL be a separate combinational sub-module rr_picker (inputs req and rr_ptr; outputs onehot winner, index and any_valid).
REQ-031 The bus_valid output of bus_arbiter SHALL connect directly to the valid_in of row_data_bus and col_data_bus; no extra register stage.

Verification
REQ-032 Single requester: req=0x0008, len[3]=2, en=1 -> next cycle grant=0x0008; bus_valid=0x0008 for 2 cycles; done[3] on the 2nd; then busy=0.
REQ-033 All requesting: req=0xFFFF, all len=1, out of reset -> owners granted 0,1,...,15,0, each burst 1 beat plus 1 IDLE cycle.
REQ-034 Stall: len=4, stall high for 3 cycles after the first beat -> exactly 4 bus_valid beats over 7 BURST cycles; done only on the 4th beat.
REQ-035 Zero length: req=0x0001, len[0]=0 -> exactly one beat and a done[0] pulse.
REQ-036 Reset mid-burst: assert rst_n=0 on beat 2 of 4 -> all outputs 0 without waiting for a clock edge; after release with req=0xFFFF, owner 0 is granted first.
REQ-037 Enable gating: en=0 with req=0xFFFF -> grant stays 0; dropping en during a len=3 burst -> all 3 beats still transfer.
